// File: rtl/arcade_rom_loader_if.sv
// Download, SDRAM write and BRAM strobe bus of the arcade ROM loader.
// master: data_io / SDRAM controller / BRAM side. slave: the loader itself.
interface arcade_rom_loader_if #(
  parameter int ADDR_W  = 25,
  parameter int REGIONS = 4
);
  logic               ioctl_download;
  logic [7:0]         ioctl_index;
  logic               ioctl_wr;
  logic [ADDR_W-1:0]  ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic               sdram_we;
  logic               sdram_ack;
  logic [ADDR_W-1:0]  sdram_addr;
  logic [15:0]        sdram_din;
  logic [1:0]         sdram_wtbt;
  logic [REGIONS-1:0] region_wr;
  logic [ADDR_W-1:0]  region_addr;
  logic [7:0]         region_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
    input  sdram_we, sdram_addr, sdram_din, sdram_wtbt, region_wr, region_addr, region_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
    output sdram_we, sdram_addr, sdram_din, sdram_wtbt, region_wr, region_addr, region_data
  );
endinterface

// File: rtl/arcade_rom_loader.sv
// ROM download glue: packs data_io bytes into 16-bit SDRAM writes through a
// 2-deep buffer, decodes BRAM windows, and sequences the game core reset.
module arcade_rom_loader #(
  parameter int                          ADDR_W     = 25,
  parameter int                          REGIONS    = 4,
  parameter logic [REGIONS*ADDR_W-1:0]   REGION_END = {25'h10000, 25'h0C000, 25'h08000, 25'h04000},
  parameter logic [7:0]                  DL_INDEX   = 8'd0,
  parameter int                          RESET_HOLD = 1024
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                reset_req,
  arcade_rom_loader_if.slave  bus,
  output logic                rom_loaded,
  output logic                core_reset,
  output logic                overrun
);

  localparam int             CW      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0]  HOLD_LD = CW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } word_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic               hv_q, hv_d;
  logic [ADDR_W-1:0]  hva_q, hva_d;
  logic [7:0]         hvd_q, hvd_d;
  word_t              fifo_q [2];
  logic               wp_q, rp_q;
  logic [1:0]         fcnt_q, fcnt_d;
  logic               ovr_q;
  logic [REGIONS-1:0] rwr_q, hit;
  logic [ADDR_W-1:0]  raddr_q, base;
  logic [7:0]         rdata_q;
  logic               acc, pop, room, push, flush_ok;
  word_t              push_w;

  assign acc  = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == DL_INDEX);
  assign pop  = bus.sdram_ack & (fcnt_q != 2'd0);
  // A full buffer can still take a word in the cycle its head is acked.
  assign room = (fcnt_q != 2'd2) | pop;
  // A pending even byte is flushed once the download strobe has dropped.
  assign flush_ok = hv_q & ~acc & ~bus.ioctl_download & ((state_q == LOAD) | (state_q == DRAIN));

  // Byte packing: pair even/odd bytes, emit half words when a pair cannot form.
  always_comb begin
    push   = 1'b0;
    push_w = '0;
    hv_d   = hv_q;
    hva_d  = hva_q;
    hvd_d  = hvd_q;
    if (acc) begin
      if (!bus.ioctl_addr[0]) begin
        if (hv_q) begin
          push   = 1'b1;
          push_w = '{addr: hva_q, data: {8'h00, hvd_q}, be: 2'b01};
        end
        hv_d  = 1'b1;
        hva_d = bus.ioctl_addr;
        hvd_d = bus.ioctl_dout;
      end else if (hv_q && (hva_q[ADDR_W-1:1] == bus.ioctl_addr[ADDR_W-1:1])) begin
        push   = 1'b1;
        push_w = '{addr: hva_q, data: {bus.ioctl_dout, hvd_q}, be: 2'b11};
        hv_d   = 1'b0;
      end else begin
        push   = 1'b1;
        push_w = '{addr: {bus.ioctl_addr[ADDR_W-1:1], 1'b0}, data: {bus.ioctl_dout, 8'h00}, be: 2'b10};
      end
    end else if (flush_ok && room) begin
      push   = 1'b1;
      push_w = '{addr: hva_q, data: {8'h00, hvd_q}, be: 2'b01};
      hv_d   = 1'b0;
    end
  end

  // Next buffer occupancy; a push into a full, unacked buffer is dropped.
  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({push & room, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Buffer pointers, occupancy, half-word latch and sticky overrun.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      fcnt_q <= 2'd0;
      ovr_q  <= 1'b0;
      hv_q   <= 1'b0;
      hva_q  <= '0;
      hvd_q  <= 8'h00;
    end else begin
      if (pop) rp_q <= ~rp_q;
      if (push && room) wp_q <= ~wp_q;
      if (push && !room) ovr_q <= 1'b1;
      fcnt_q <= fcnt_d;
      hv_q   <= hv_d;
      hva_q  <= hva_d;
      hvd_q  <= hvd_d;
    end
  end

  // Buffer storage; outputs are gated by occupancy so it needs no reset.
  always_ff @(posedge clk_sys) begin
    if (push && room) fifo_q[wp_q] <= push_w;
  end

  // Window decode: window i spans [END[i-1], END[i]) with END[-1] = 0.
  always_comb begin
    logic [ADDR_W-1:0] lo, hi;
    lo   = '0;
    hi   = '0;
    hit  = '0;
    base = '0;
    for (int i = 0; i < REGIONS; i++) begin
      hi = REGION_END[i*ADDR_W +: ADDR_W];
      if ((bus.ioctl_addr >= lo) && (bus.ioctl_addr < hi)) begin
        hit[i] = 1'b1;
        base   = lo;
      end
      lo = hi;
    end
  end

  // Registered BRAM strobe, window-local address and byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rwr_q   <= '0;
      raddr_q <= '0;
      rdata_q <= 8'h00;
    end else begin
      rwr_q <= acc ? hit : '0;
      if (acc) begin
        raddr_q <= bus.ioctl_addr - base;
        rdata_q <= bus.ioctl_dout;
      end
    end
  end

  // Load / drain / hold / run sequencing of the core reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    unique case (state_q)
      IDLE: if (acc) begin
        state_d  = LOAD;
        loaded_d = 1'b0;
      end
      LOAD: if (!bus.ioctl_download) state_d = DRAIN;
      // HOLD starts in the cycle the last word is acked.
      DRAIN: if (acc) begin
        state_d = LOAD;
      end else if (!hv_q && (fcnt_d == 2'd0)) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
      HOLD: if (acc) begin
        state_d  = LOAD;
        loaded_d = 1'b0;
      end else if (reset_req) begin
        cnt_d = HOLD_LD;
      end else if (cnt_q == '0) begin
        state_d  = RUN;
        loaded_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RUN: if (acc) begin
        state_d  = LOAD;
        loaded_d = 1'b0;
      end else if (reset_req) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

  // reset_req reaches the core immediately so the hold covers the whole press.
  assign core_reset     = (state_q != RUN) | reset_req;
  assign rom_loaded     = loaded_q;
  assign overrun        = ovr_q;
  assign bus.sdram_we   = (fcnt_q != 2'd0);
  assign bus.sdram_addr = bus.sdram_we ? fifo_q[rp_q].addr : '0;
  assign bus.sdram_din  = bus.sdram_we ? fifo_q[rp_q].data : 16'h0000;
  assign bus.sdram_wtbt = bus.sdram_we ? fifo_q[rp_q].be   : 2'b00;
  assign bus.region_wr   = rwr_q;
  assign bus.region_addr = raddr_q;
  assign bus.region_data = rdata_q;

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Directed bench for arcade_rom_loader with a queue-based model of the SDRAM
// write stream and window decode, checked every cycle, plus literal pins.
module tb_arcade_rom_loader;
  localparam int AW = 25;
  localparam int NR = 4;
  localparam int RH = 16;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic reset_req = 1'b0;
  logic rom_loaded, core_reset, overrun;

  arcade_rom_loader_if #(.ADDR_W(AW), .REGIONS(NR)) bus();

  arcade_rom_loader #(.ADDR_W(AW), .REGIONS(NR), .RESET_HOLD(RH)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .reset_req  (reset_req),
    .bus        (bus),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset),
    .overrun    (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
  } mw_t;

  mw_t           mq[$];
  bit            m_ovr, m_half;
  logic [AW-1:0] m_ha, m_raddr;
  logic [7:0]    m_hd, m_rdata;
  logic [NR-1:0] m_rwr;
  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovr = 0; m_half = 0; m_rwr = '0;
    m_ha = '0; m_hd = '0; m_raddr = '0; m_rdata = '0;
  endtask

  // Spec rules on the byte stream: pairing, half words, 2-entry buffer, windows.
  task automatic model_step();
    bit acc, have;
    mw_t w;
    logic [AW-1:0] a;
    acc  = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == 8'd0);
    a    = bus.ioctl_addr;
    have = 0;
    w    = '0;
    if (bus.sdram_ack && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      m_rdata = bus.ioctl_dout;
      if      (a < 25'h04000) begin m_rwr = 4'b0001; m_raddr = a; end
      else if (a < 25'h08000) begin m_rwr = 4'b0010; m_raddr = a - 25'h04000; end
      else if (a < 25'h0C000) begin m_rwr = 4'b0100; m_raddr = a - 25'h08000; end
      else if (a < 25'h10000) begin m_rwr = 4'b1000; m_raddr = a - 25'h0C000; end
      else m_rwr = 4'b0000;
      if (a[0] == 1'b0) begin
        if (m_half) begin w = {m_ha, 8'h00, m_hd, 2'b01}; have = 1; end
        m_half = 1; m_ha = a; m_hd = bus.ioctl_dout;
      end else if (m_half && (m_ha + 1 == a)) begin
        w = {m_ha, bus.ioctl_dout, m_hd, 2'b11}; have = 1; m_half = 0;
      end else begin
        w = {a - 25'd1, bus.ioctl_dout, 8'h00, 2'b10}; have = 1;
      end
    end else begin
      m_rwr = '0;
      if (!bus.ioctl_download && m_half && mq.size() < 2) begin
        w = {m_ha, 8'h00, m_hd, 2'b01}; have = 1; m_half = 0;
      end
    end
    if (have) begin
      if (mq.size() < 2) mq.push_back(w);
      else m_ovr = 1;
    end
  endtask

  task automatic compare();
    chk("sdram_we", bus.sdram_we, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("sdram_addr", bus.sdram_addr, mq[0].addr);
      chk("sdram_din",  bus.sdram_din,  mq[0].data);
      chk("sdram_wtbt", bus.sdram_wtbt, mq[0].be);
    end
    chk("region_wr", bus.region_wr, m_rwr);
    if (m_rwr != 0) begin
      chk("region_addr", bus.region_addr, m_raddr);
      chk("region_data", bus.region_data, m_rdata);
    end
    chk("overrun", overrun, m_ovr);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    if (reset) model_clear(); else model_step();
    @(negedge clk_sys);
    cyc++;
    compare();
  endtask

  task automatic send(input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.sdram_we) break;
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      n++;
    end
  endtask

  task automatic wait_loaded(input string nm, output int t, output logic prev_cr);
    t = -1;
    prev_cr = core_reset;
    for (int i = 0; i < RH + 40; i++) begin
      tick();
      if (rom_loaded) begin t = cyc; break; end
      prev_cr = core_reset;
    end
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL %s timeout rom_loaded actual=0 required=1", nm);
    end
  endtask

  initial begin
    int   ack_t, t, n, rise, fall;
    logic pcr;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = 8'h00; bus.sdram_ack = 1'b0;
    model_clear();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_sdram_we",   bus.sdram_we, 0);
    chk("rst_region_wr",  bus.region_wr, 0);
    chk("rst_overrun",    overrun, 0);

    // Two bytes form one full word; ack after 3 cycles.
    bus.ioctl_download = 1'b1;
    send(8'd0, 25'd0, 8'h11);
    chk("half_no_we", bus.sdram_we, 0);
    send(8'd0, 25'd1, 8'h22);
    chk("w1_we",   bus.sdram_we, 1);
    chk("w1_addr", bus.sdram_addr, 25'd0);
    chk("w1_din",  bus.sdram_din, 16'h2211);
    chk("w1_wtbt", bus.sdram_wtbt, 2'b11);
    tick(); tick();
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    chk("w1_we_after_ack", bus.sdram_we, 0);

    // Trailing even byte is flushed as a half word when the download ends.
    send(8'd0, 25'd2, 8'h33);
    bus.ioctl_download = 1'b0;
    tick();
    chk("w2_addr",    bus.sdram_addr, 25'd2);
    chk("w2_din_lo",  bus.sdram_din[7:0], 8'h33);
    chk("w2_wtbt",    bus.sdram_wtbt, 2'b01);
    chk("dl_core_rst", core_reset, 1);
    tick(); tick();
    bus.sdram_ack = 1'b1; ack_t = cyc; tick(); bus.sdram_ack = 1'b0;
    wait_loaded("hold1", t, pcr);
    // The ack raised at tick ack_t is taken on the next edge; RH edges later
    // rom_loaded rises, first seen at the tick after that edge.
    chk("hold_len",     t - ack_t, RH + 1);
    chk("cr_before_run", pcr, 1);
    chk("cr_fall_run",   core_reset, 0);

    // Window decode and odd-only byte.
    bus.ioctl_download = 1'b1;
    send(8'd0, 25'h4005, 8'hA5);
    chk("win1_wr",     bus.region_wr, 4'b0010);
    chk("win1_addr",   bus.region_addr, 25'h5);
    chk("win1_data",   bus.region_data, 8'hA5);
    chk("odd_addr",    bus.sdram_addr, 25'h4004);
    chk("odd_din",     bus.sdram_din, 16'hA500);
    chk("odd_wtbt",    bus.sdram_wtbt, 2'b10);
    chk("reload_rom_loaded", rom_loaded, 0);
    chk("reload_core_reset", core_reset, 1);
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    send(8'd0, 25'h10000, 8'h5A);
    chk("nowin_wr", bus.region_wr, 4'b0000);
    bus.ioctl_download = 1'b0;
    tick();
    chk("nowin_sdram_addr", bus.sdram_addr, 25'h10000);
    chk("nowin_sdram_din",  bus.sdram_din, 16'h005A);
    drain(n);
    wait_loaded("hold2", t, pcr);

    // Five complete pairs with ack withheld: two kept, the rest dropped.
    bus.ioctl_download = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(8'd0, 25'h100 + 25'(2*k), 8'(2*k + 1));
      send(8'd0, 25'h101 + 25'(2*k), 8'(2*k + 2));
    end
    chk("ovr_set",  overrun, 1);
    chk("ovr_head_addr", bus.sdram_addr, 25'h100);
    chk("ovr_head_din",  bus.sdram_din, 16'h0201);
    bus.ioctl_download = 1'b0;
    tick();
    drain(n);
    chk("ovr_drained", n, 2);
    chk("ovr_sticky", overrun, 1);
    wait_loaded("hold3", t, pcr);

    // User reset for 10 cycles in RUN.
    chk("run_core_reset", core_reset, 0);
    reset_req = 1'b1; rise = cyc;
    for (int i = 0; i < 10; i++) tick();
    reset_req = 1'b0;
    fall = -1;
    for (int i = 0; i < RH + 40; i++) begin
      tick();
      if (!core_reset) begin fall = cyc; break; end
    end
    chk("req_hold_len", fall - rise, 10 + RH);
    chk("req_rom_loaded", rom_loaded, 1);

    // Other download index is ignored.
    bus.ioctl_download = 1'b1;
    for (int k = 0; k < 4; k++) send(8'd1, 25'(k), 8'(8'hC0 + k));
    bus.ioctl_download = 1'b0;
    tick(); tick();
    chk("idx1_sdram_we",   bus.sdram_we, 0);
    chk("idx1_core_reset", core_reset, 0);
    chk("idx1_rom_loaded", rom_loaded, 1);

    // Asynchronous reset in the middle of a load.
    bus.ioctl_download = 1'b1;
    send(8'd0, 25'h20, 8'h01);
    send(8'd0, 25'h21, 8'h02);
    chk("mid_we", bus.sdram_we, 1);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("arst_core_reset", core_reset, 1);
    chk("arst_rom_loaded", rom_loaded, 0);
    chk("arst_sdram_we",   bus.sdram_we, 0);
    chk("arst_overrun",    overrun, 0);
    bus.ioctl_download = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_core_reset", core_reset, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
